// File: rtl/sram_scan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_scan_pkg : shared types, scan-chain geometry and synchronizer reset
//                 values for the SRAM scan controller.
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
package sram_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int c_def_addr_w  = 16;
  localparam int c_def_data_w  = 32;
  localparam int c_def_wmask_w = 4;
  localparam int c_def_sel_w   = 4;

  // Synchronized inputs, MSB first: {scan_en, scan_in, sram_load, global_csb}
  localparam int         c_sync_n   = 4;
  localparam logic [3:0] c_sync_rst = 4'b0001;

  // One port slice, LSB up: wmask, web, csb, din, addr
  function automatic int port_w(input int aw, input int dw, input int mw);
    return aw + dw + 2 + mw;
  endfunction

  function automatic int chain_len(input int sw, input int aw, input int dw, input int mw);
    return sw + 2 * port_w(aw, dw, mw);
  endfunction

  function automatic int off_web(input int mw);
    return mw;
  endfunction

  function automatic int off_csb(input int mw);
    return mw + 1;
  endfunction

  function automatic int off_din(input int mw);
    return mw + 2;
  endfunction

  function automatic int off_addr(input int dw, input int mw);
    return mw + 2 + dw;
  endfunction

  localparam int c_def_chain_l = chain_len(c_def_sel_w, c_def_addr_w, c_def_data_w, c_def_wmask_w);

endpackage
`default_nettype wire

// File: rtl/sram_scan_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_scan_ctrl_if : dual-port SRAM macro bus driven by the scan controller.
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
interface sram_scan_ctrl_if
  import sram_scan_pkg::*;
#(
  parameter int ADDR_W  = c_def_addr_w,
  parameter int DATA_W  = c_def_data_w,
  parameter int WMASK_W = c_def_wmask_w,
  parameter int SEL_W   = c_def_sel_w
);
  logic [SEL_W-1:0]   sel;
  logic [ADDR_W-1:0]  addr0;
  logic [ADDR_W-1:0]  addr1;
  logic [DATA_W-1:0]  din0;
  logic [DATA_W-1:0]  din1;
  logic               csb0;
  logic               csb1;
  logic               web0;
  logic               web1;
  logic [WMASK_W-1:0] wmask0;
  logic [WMASK_W-1:0] wmask1;
  logic [DATA_W-1:0]  rdata0;
  logic [DATA_W-1:0]  rdata1;

  modport master (
    output sel, addr0, addr1, din0, din1, csb0, csb1, web0, web1, wmask0, wmask1,
    input  rdata0, rdata1
  );

  modport slave (
    input  sel, addr0, addr1, din0, din1, csb0, csb1, web0, web1, wmask0, wmask1,
    output rdata0, rdata1
  );
endinterface
`default_nettype wire

// File: rtl/sram_scan_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_scan_sync : WIDTH-bit two-flop synchronizer with per-bit reset value.
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
module sram_scan_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/sram_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram_scan_ctrl : scan-loaded dual-port SRAM access controller with readback
//                  capture. Define SRAM_SCAN_SYNC_EN to synchronize inputs.
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
module sram_scan_ctrl
  import sram_scan_pkg::*;
#(
  parameter int ADDR_W   = c_def_addr_w,
  parameter int DATA_W   = c_def_data_w,
  parameter int WMASK_W  = c_def_wmask_w,
  parameter int SEL_W    = c_def_sel_w,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             sram_load,
  input  logic             global_csb,
  sram_scan_ctrl_if.master sram,
  output logic             busy
);
  localparam int c_pw      = port_w(ADDR_W, DATA_W, WMASK_W);
  localparam int c_len     = chain_len(SEL_W, ADDR_W, DATA_W, WMASK_W);
  localparam int c_p0      = c_pw;
  localparam int c_p1      = 0;
  localparam int c_sel_lsb = 2 * c_pw;
  localparam int c_o_web   = off_web(WMASK_W);
  localparam int c_o_csb   = off_csb(WMASK_W);
  localparam int c_o_din   = off_din(WMASK_W);
  localparam int c_o_addr  = off_addr(DATA_W, WMASK_W);
  localparam int c_cnt_w   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(READ_LAT - 1);

  logic w_scan_en;
  logic w_scan_in;
  logic w_load;
  logic w_csb;

`ifdef SRAM_SCAN_SYNC_EN
  logic [c_sync_n-1:0] w_sync_q;

  sram_scan_sync #(
    .WIDTH   (c_sync_n),
    .RST_VAL (c_sync_rst)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      ({scan_en, scan_in, sram_load, global_csb}),
    .q      (w_sync_q)
  );

  assign {w_scan_en, w_scan_in, w_load, w_csb} = w_sync_q;
`else
  assign w_scan_en = scan_en;
  assign w_scan_in = scan_in;
  assign w_load    = sram_load;
  assign w_csb     = global_csb;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_len-1:0]   r_chain;
  logic [c_len-1:0]   w_chain_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_csb_prev;
  logic               w_trig;
  logic               w_access;

  // A falling trigger edge only counts while the chain is not shifting.
  assign w_trig = r_csb_prev & ~w_csb & ~w_scan_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_chain    <= '0;
      r_cnt      <= '0;
      r_csb_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_chain    <= w_chain_nxt;
      r_cnt      <= w_cnt_nxt;
      r_csb_prev <= w_csb;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_chain_nxt = r_chain;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_state_nxt = ST_ACCESS;
        end else if (w_scan_en) begin
          w_chain_nxt = {r_chain[c_len-2:0], w_scan_in};
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (r_cnt == c_wait_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        // Trigger beats shifting, which beats (and discards) the capture.
        if (w_trig) begin
          w_state_nxt = ST_ACCESS;
        end else if (w_scan_en) begin
          w_state_nxt = ST_IDLE;
          w_chain_nxt = {r_chain[c_len-2:0], w_scan_in};
        end else if (w_load) begin
          w_state_nxt = ST_IDLE;
          if (!r_chain[c_p0+c_o_csb] && r_chain[c_p0+c_o_web]) begin
            w_chain_nxt[c_p0+c_o_din +: DATA_W] = sram.rdata0;
          end
          if (!r_chain[c_p1+c_o_csb] && r_chain[c_p1+c_o_web]) begin
            w_chain_nxt[c_p1+c_o_din +: DATA_W] = sram.rdata1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_access    = (r_state == ST_ACCESS);
  assign busy        = (r_state != ST_IDLE);
  assign scan_out    = r_chain[c_len-1];

  assign sram.sel    = r_chain[c_sel_lsb +: SEL_W];
  assign sram.addr0  = r_chain[c_p0+c_o_addr +: ADDR_W];
  assign sram.din0   = r_chain[c_p0+c_o_din +: DATA_W];
  assign sram.wmask0 = r_chain[c_p0 +: WMASK_W];
  assign sram.csb0   = w_access ? r_chain[c_p0+c_o_csb] : 1'b1;
  assign sram.web0   = w_access ? r_chain[c_p0+c_o_web] : 1'b1;
  assign sram.addr1  = r_chain[c_p1+c_o_addr +: ADDR_W];
  assign sram.din1   = r_chain[c_p1+c_o_din +: DATA_W];
  assign sram.wmask1 = r_chain[c_p1 +: WMASK_W];
  assign sram.csb1   = w_access ? r_chain[c_p1+c_o_csb] : 1'b1;
  assign sram.web1   = w_access ? r_chain[c_p1+c_o_web] : 1'b1;
endmodule
`default_nettype wire

// File: tb/tb_sram_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sram_scan_ctrl : scoreboard bench for sram_scan_ctrl with a packet-level
//                     reference model and a behavioural SRAM read model.
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sram_scan_ctrl;
  import sram_scan_pkg::*;

`ifdef SRAM_SCAN_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int L = 112;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr0;
    logic [31:0] din0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [15:0] addr1;
    logic [31:0] din1;
    logic        csb1;
    logic        web1;
    logic [3:0]  wmask1;
  } pkt_t;

  typedef struct {
    pkt_t p;
    int   cyc;
  } acc_t;

  logic clk        = 1'b0;
  logic resetn     = 1'b0;
  logic scan_en    = 1'b0;
  logic scan_in    = 1'b0;
  logic sram_load  = 1'b0;
  logic global_csb = 1'b1;
  logic scan_out;
  logic busy;

  sram_scan_ctrl_if sram ();

  sram_scan_ctrl u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .sram_load  (sram_load),
    .global_csb (global_csb),
    .sram       (sram),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  pkt_t mdl   = '0;
  bit   exp_bits[$];
  acc_t exp_acc[$];
  bit   rd_scramble = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_fn(input int port, input logic [15:0] a);
    if (!rd_scramble) return {16'h0, a};
    return ({16'h0, a} * 32'h9E37_79B1) ^ ((port == 0) ? 32'h0F0F_1234 : 32'hA5A5_5A5A);
  endfunction

  // SRAM read port: registered data, held until the next read.
  always @(posedge clk) begin
    if (!sram.csb0 && sram.web0) sram.rdata0 <= rd_fn(0, sram.addr0);
    if (!sram.csb1 && sram.web1) sram.rdata1 <= rd_fn(1, sram.addr1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: scan_out against expected stream, accesses against queue.
  logic [1:0] en_hist = 2'b00;
  always @(negedge clk) begin : mon
    logic eff;
    bit   b;
    acc_t a;
    pkt_t o;
    eff     = (SYNC_LAT == 0) ? scan_en : en_hist[1];
    en_hist = {en_hist[0], scan_en};
    if (eff && resetn && exp_bits.size() > 0) begin
      b = exp_bits.pop_front();
      chk("scan_out_bit", {127'h0, scan_out}, {127'h0, b});
    end
    if (resetn && (!sram.csb0 || !sram.csb1)) begin
      if (exp_acc.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_access: csb0=%0b csb1=%0b with none pending (cycle %0d)",
                 sram.csb0, sram.csb1, cyc);
      end else begin
        a = exp_acc.pop_front();
        o = {sram.sel, sram.addr0, sram.din0, sram.csb0, sram.web0, sram.wmask0,
             sram.addr1, sram.din1, sram.csb1, sram.web1, sram.wmask1};
        chk("access_fields", o, a.p);
        chk("access_cycle", cyc, a.cyc);
      end
    end else begin
      chk("inactive_web", {126'h0, sram.web0, sram.web1}, 128'h3);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.sel    = 4'($urandom);
    p.addr0  = 16'($urandom);
    p.din0   = $urandom;
    p.csb0   = 1'($urandom_range(0, 1));
    p.web0   = 1'($urandom_range(0, 1));
    p.wmask0 = 4'($urandom);
    p.addr1  = 16'($urandom);
    p.din1   = $urandom;
    p.csb1   = 1'($urandom_range(0, 1));
    p.web1   = 1'($urandom_range(0, 1));
    p.wmask1 = 4'($urandom);
    if (p.csb0 && p.csb1) p.csb0 = 1'b0;
    return p;
  endfunction

  // Full-length shift: the old chain comes out MSB first as the new one goes in.
  task automatic shift_pkt(input pkt_t p, input bit glitch);
    logic [L-1:0] vo;
    logic [L-1:0] vi;
    vo = mdl;
    vi = p;
    for (int i = 0; i < L; i++) exp_bits.push_back(vo[L-1-i]);
    for (int i = 0; i < L; i++) begin
      scan_en = 1'b1;
      scan_in = vi[L-1-i];
      if (glitch && i == 40) global_csb = 1'b0;
      if (glitch && i == 43) global_csb = 1'b1;
      if (glitch && i == 48) chk("busy_during_shift_trigger", {127'h0, busy}, 128'h0);
      tick(1);
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
    tick(SYNC_LAT + 2);
    mdl = p;
  endtask

  task automatic trigger();
    acc_t a;
    a.p   = mdl;
    a.cyc = cyc + 1 + SYNC_LAT;
    exp_acc.push_back(a);
    global_csb = 1'b0;
    tick(1);
    global_csb = 1'b1;
  endtask

  task automatic wait_done();
    tick(3 + SYNC_LAT);
    chk("busy_in_done", {127'h0, busy}, 128'h1);
  endtask

  task automatic load_pkt();
    if (!mdl.csb0 && mdl.web0) mdl.din0 = rd_fn(0, mdl.addr0);
    if (!mdl.csb1 && mdl.web1) mdl.din1 = rd_fn(1, mdl.addr1);
    sram_load = 1'b1;
    tick(1);
    sram_load = 1'b0;
    tick(SYNC_LAT + 2);
    chk("busy_after_load", {127'h0, busy}, 128'h0);
  endtask

  initial begin : stim
    pkt_t p;
    tick(3);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    chk("rst_scan_out", {127'h0, scan_out}, 128'h0);
    chk("rst_csb_web", {124'h0, sram.csb0, sram.csb1, sram.web0, sram.web1}, 128'hF);
    chk("rst_fields", {sram.sel, sram.addr0, sram.din0, sram.wmask0, sram.addr1, sram.din1, sram.wmask1}, 128'h0);
    resetn = 1'b1;
    tick(2);

    // Write packet on port 0 only; no capture on load.
    p        = '0;
    p.addr0  = 16'h1;
    p.din0   = 32'h1;
    p.wmask0 = 4'hF;
    p.csb1   = 1'b1;
    p.web1   = 1'b1;
    shift_pkt(p, 1'b0);
    trigger();
    wait_done();
    load_pkt();

    // Dual read packet; trigger attempted mid-shift must be ignored.
    p       = '0;
    p.sel   = 4'h5;
    p.addr0 = 16'h1;
    p.addr1 = 16'h2;
    p.din0  = 32'hDEAD_0000;
    p.din1  = 32'h0000_BEEF;
    p.web0  = 1'b1;
    p.web1  = 1'b1;
    shift_pkt(p, 1'b1);
    trigger();
    wait_done();
    load_pkt();

    // Load while idle must not disturb the chain.
    p = rand_pkt();
    shift_pkt(p, 1'b0);
    sram_load = 1'b1;
    tick(1);
    sram_load = 1'b0;
    tick(SYNC_LAT + 2);
    chk("busy_idle_load", {127'h0, busy}, 128'h0);

    rd_scramble = 1'b1;
    for (int it = 0; it < 24; it++) begin
      p = rand_pkt();
      shift_pkt(p, ($urandom_range(0, 3) == 0));
      trigger();
      wait_done();
      case ($urandom_range(0, 3))
        0, 1: load_pkt();
        2: begin
          trigger();
          wait_done();
          load_pkt();
        end
        default: ;
      endcase
    end

    // Reset while waiting for read data.
    p = rand_pkt();
    shift_pkt(p, 1'b0);
    trigger();
    tick(1 + SYNC_LAT);
    chk("wait_busy_before_reset", {127'h0, busy}, 128'h1);
    resetn = 1'b0;
    #1;
    chk("reset_csb", {126'h0, sram.csb0, sram.csb1}, 128'h3);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_scan_out", {127'h0, scan_out}, 128'h0);
    mdl = '0;
    tick(2);
    resetn = 1'b1;
    tick(3);
    chk("idle_after_reset", {127'h0, busy}, 128'h0);

    p = rand_pkt();
    shift_pkt(p, 1'b0);
    chk("pending_accesses", exp_acc.size(), 0);
    chk("pending_bits", exp_bits.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/sram_scan_ctrl.md
SRAM_SCAN_CTRL -- requirements
Module: sram_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, SRAM address width per port.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width per port.
REQ-003 SHALL have parameter WMASK_W, default 4, write-mask width per port.
REQ-004 SHALL have parameter SEL_W, default 4, macro-select width.
REQ-005 SHALL have parameter READ_LAT, default 1, clocks from access cycle to valid rdata.
REQ-006 SHALL have ports:
 clk  in  1  sole clock, used on rising edge;
 resetn  in  1  asynchronous, active-low reset;
 scan_en  in  1  shift enable;
 scan_in  in  1  serial data in;
 scan_out  out  1  serial data out, equal to chain MSB;
 sram_load  in  1  capture read data into chain;
 global_csb  in  1  access trigger, active on high-to-low edge;
 sel  out  SEL_W  macro select;
 addr0/addr1  out  ADDR_W  port address;
 din0/din1  out  DATA_W  port write data;
 csb0/csb1  out  1  port chip select, active-low;
 web0/web1  out  1  port write enable, active-low;
 wmask0/wmask1  out  WMASK_W  port write mask;
 rdata0/rdata1  in  DATA_W  read data from the selected macro;
 busy  out  1  high in states ACCESS, WAIT and DONE.

Function
REQ-007 SHALL hold a chain of L = SEL_W + 2*(ADDR_W+DATA_W+2+WMASK_W) bits (112 at defaults), MSB first: {sel, addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1}.
REQ-008 SHALL shift on each clock with scan_en=1: chain <= {chain[L-2:0], scan_in}; scan_out = chain[L-1] combinationally.
REQ-009 SHALL use FSM states IDLE, ACCESS, WAIT, DONE.
REQ-010 SHALL move IDLE or DONE -> ACCESS on a sampled global_csb falling edge while scan_en=0; with scan_en=1 the edge is ignored.
REQ-011 SHALL, for exactly one cycle in ACCESS, drive every port output from its chain field; the chain is frozen from ACCESS through DONE.
REQ-012 SHALL, in all states other than ACCESS, drive csb0=csb1=1 and web0=web1=1; sel, addr, din and wmask hold their chain fields.
REQ-013 SHALL go ACCESS -> WAIT, stay in WAIT for READ_LAT cycles, then go WAIT -> DONE.
REQ-014 SHALL, in DONE with sram_load=1, write rdata0 into the din0 field only if chain csb0=0 and web0=1, and likewise for port 1, then go to IDLE; all other fields SHALL be unchanged.
REQ-015 SHALL ignore sram_load outside DONE and SHALL remain in DONE until load or a new trigger.
REQ-016 SHALL, if scan_en=1 in ACCESS or WAIT, finish the access and not shift the chain; shifting resumes in IDLE or DONE.
REQ-017 SHALL, if scan_en=1 in DONE, go DONE -> IDLE and shift, discarding the capture.
REQ-018 SHALL apply priority trigger > load when both occur in DONE.

Reset
REQ-019 SHALL, on resetn=0, asynchronously clear the chain and edge register, go to IDLE, and drive scan_out=0, csb0=csb1=1, web0=web1=1, busy=0, and all other outputs 0.
REQ-020 SHALL, on reset during ACCESS or WAIT, abort the access with no capture.

Configuration
REQ-021 SHALL, with SRAM_SCAN_SYNC_EN defined, pass scan_en, scan_in, sram_load and global_csb through 2-flop synchronizers reset to 0,0,0,1, adding 2 cycles of latency; without it, these inputs are sampled directly.

Structure
REQ-022 SHALL place the state enum, field widths, field offsets, chain length L and sync-reset constants in package sram_scan_pkg.
REQ-023 SHALL implement synchronizers as sub-module sram_scan_sync, instantiated only under SRAM_SCAN_SYNC_EN.

Verification
REQ-024 SHALL cover: shift 112 bits {0,1,1,0,0,F,0,0,1,1,0}, then pulse global_csb -> one cycle with sel=0, addr0=1, din0=1, csb0=0, web0=0, wmask0=F, csb1=1.
REQ-025 SHALL cover: read packet addr0=1, addr1=2, both csb=0 and web=1, with model rdata0=1 and rdata1=2, then load and shift out -> din0 field=1, din1 field=2, all other bits as shifted in.
REQ-026 SHALL cover: global_csb falling while scan_en=1 -> csb0/csb1 stay 1 and busy stays 0.
REQ-027 SHALL cover: sram_load in IDLE -> 112 shifted-out bits equal those shifted in.
REQ-028 SHALL cover: resetn low during WAIT -> csb0/csb1=1 and busy=0 immediately, and IDLE after release.
REQ-029 SHALL cover: SRAM_SCAN_SYNC_EN defined -> ACCESS cycle occurs exactly 2 cycles later than without the macro.
